sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Parametrised single-clock FIFO replacing the pass-through FIFO stub with real storage. Supports arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty thresholds and a synchronous bulk preload. Sits between producer/consumer stages in one clock domain; preload initialises test patterns or command queues.

Parameters:
DATA_WIDTH, 16, bits per entry
DEPTH, 8, number of entries; legal range 2..1024, not required to be a power of two
ALMOST_FULL_TH, DEPTH-1, almostFull asserted when count >= this value
ALMOST_EMPTY_TH, 1, almostEmpty asserted when count <= this value

Ports:
clkIn  input  1  clock; all logic on rising edge
resetIn  input  1  synchronous reset, active-high
writeEnableIn  input  1  push request
dataIn  input  DATA_WIDTH  push data
readEnableIn  input  1  pop request
loadEnableIn  input  1  bulk preload strobe
loadIn  input  DEPTH*DATA_WIDTH  preload image; entry i = loadIn[i*DATA_WIDTH +: DATA_WIDTH]
loadCountIn  input  $clog2(DEPTH+1)  number of valid entries after preload
dataOut  output  DATA_WIDTH  registered read data
dataValidOut  output  1  dataOut holds freshly popped word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almostFull  output  1  count >= ALMOST_FULL_TH
almostEmpty  output  1  count <= ALMOST_EMPTY_TH
count  output  $clog2(DEPTH+1)  current occupancy
overflowOut  output  1  sticky write-while-full error (see Optional Feature)
underflowOut  output  1  sticky read-while-empty error (see Optional Feature)

Behaviour:
- Reset (resetIn=1 at edge): head=0, tail=0, count=0, dataOut=0, dataValidOut=0, empty=1, full=0, almostEmpty=1, almostFull=(ALMOST_FULL_TH==0), overflowOut=0, underflowOut=0. Storage not cleared. Reset overrides all other inputs, including an in-flight load.
- Priority per edge: reset > load > read/write.
- Write accepted iff writeEnableIn && (!full || readAccepted). Stores dataIn at tail; tail advances.
- Read accepted iff readEnableIn && !empty. mem[head] -> dataOut at that edge (1-cycle latency); dataValidOut=1 the following cycle only; head advances. Rejected read: dataOut holds, dataValidOut=0.
- Empty + read + write same cycle: write accepted, read rejected (no bypass); count 0->1.
- Full + read + write same cycle: both accepted; count stays DEPTH.
- Pointers wrap explicitly: ptr==DEPTH-1 -> 0 (no power-of-two masking).
- count: +1 write only, -1 read only, unchanged both/neither. Flags are registered and derived from next-count, so they are valid in the same cycle as count.
- Load: mem[i]=loadIn entry i for all i; head=0; count=min(loadCountIn, DEPTH); tail=count mod DEPTH; dataValidOut=0; read/write ignored that cycle; error flags cleared.

Optional Feature:
SYNC_FIFO_ERR_FLAGS_EN: when defined, overflowOut sets on a rejected write (writeEnableIn && full && !readAccepted) and underflowOut sets on a rejected read; both are sticky until reset or load. When undefined, both ports are tied 0 and no flag registers are generated. Ports exist in both builds.

Decomposition:
- Package sync_fifo_pkg: function ptr_next(ptr, depth) for explicit wrap; localparams PTR_W=$clog2(DEPTH), CNT_W=$clog2(DEPTH+1) derived in-module from the package helper.
- Sub-module fifo_wrap_ptr: PTR_W register with increment/wrap and synchronous clear/load; instantiated twice (head, tail).

Test Plan:
- Reset, then write 0x1111..0x8888 (DEPTH=8) -> full=1 after 8th edge, count=8, almostFull from count=7; 9th write rejected (overflowOut=1 if ERR_FLAGS_EN).
- Read 8 times from full -> dataOut 0x1111..0x8888 in order, one cycle after each readEnableIn, dataValidOut pulsed; empty=1 at end; extra read sets underflowOut.
- DEPTH=5: 12 writes interleaved with reads, 2 in flight -> wrap 4->0 correct, data order preserved, count never exceeds 2.
- Full + simultaneous read/write -> count stays 8, old head popped, new word lands at tail; empty + both -> count=1, dataValidOut=0.
- Load with loadCountIn=3, image 0xA0..0xA7 -> count=3, tail=3; three reads return 0xA0, 0xA1, 0xA2, then empty; loadCountIn=15 saturates to 8, full=1.
- Assert resetIn during load and during streaming -> all outputs at reset values the next cycle; loaded data not used.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the sync_fifo block.
//   ptr_next(ptr, depth) : next value of a ring pointer over 0..depth-1.
//                          Wraps explicitly at depth-1, so it is correct for
//                          depths that are not a power of two.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wrap_ptr
// Ring pointer for sync_fifo (instantiated for head and tail).
// Ports:
//   i_clk      : clock, rising edge
//   i_srst     : synchronous active-high reset, clears pointer to 0
//   i_load     : load i_load_val (takes priority over i_inc)
//   i_load_val : value loaded when i_load is high
//   i_inc      : advance pointer by one with wrap at DEPTH-1
//   o_ptr      : current pointer value
// -----------------------------------------------------------------------------
module fifo_wrap_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic [PTR_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);
  import sync_fifo_pkg::*;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_ptr_inc = PTR_W'(ptr_next(32'(r_ptr), DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= w_ptr_inc;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full / almost-empty thresholds and a synchronous bulk preload.
// Optional build macro: SYNC_FIFO_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags; without it both ports are tied low.
// Ports:
//   clkIn          : clock, rising edge
//   resetIn        : synchronous active-high reset (beats load and read/write)
//   writeEnableIn  : push request, dataIn : push data
//   readEnableIn   : pop request
//   loadEnableIn   : bulk preload strobe (beats read/write)
//   loadIn         : preload image, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   loadCountIn    : entries valid after preload (saturates at DEPTH)
//   dataOut        : registered pop data, 1-cycle latency
//   dataValidOut   : dataOut was popped on the last edge
//   full/empty/almostFull/almostEmpty/count : registered occupancy status
//   overflowOut/underflowOut : sticky rejected-write / rejected-read flags
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                          clkIn,
  input  logic                          resetIn,
  input  logic                          writeEnableIn,
  input  logic [DATA_WIDTH-1:0]         dataIn,
  input  logic                          readEnableIn,
  input  logic                          loadEnableIn,
  input  logic [DEPTH*DATA_WIDTH-1:0]   loadIn,
  input  logic [$clog2(DEPTH+1)-1:0]    loadCountIn,
  output logic [DATA_WIDTH-1:0]         dataOut,
  output logic                          dataValidOut,
  output logic                          full,
  output logic                          empty,
  output logic                          almostFull,
  output logic                          almostEmpty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflowOut,
  output logic                          underflowOut
);
  import sync_fifo_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] AE_TH   = CNT_W'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;

  logic [PTR_W-1:0]      w_head;
  logic [PTR_W-1:0]      w_tail;
  logic [PTR_W-1:0]      w_load_tail;
  logic [CNT_W-1:0]      w_load_cnt;
  logic [CNT_W-1:0]      w_count_next;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  // Load and reset suppress normal traffic. A write into a full FIFO is
  // accepted only when a pop frees the head slot on the same edge; an empty
  // FIFO never bypasses a same-cycle write to the read side.
  assign w_rd_acc = readEnableIn && !r_empty && !loadEnableIn && !resetIn;
  assign w_wr_acc = writeEnableIn && (!r_full || w_rd_acc) && !loadEnableIn && !resetIn;

  assign w_load_cnt  = (loadCountIn > DEPTH_C) ? DEPTH_C : loadCountIn;
  // A full preload leaves tail back at slot 0.
  assign w_load_tail = (w_load_cnt == DEPTH_C) ? '0 : PTR_W'(w_load_cnt);

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .i_clk      (clkIn),
    .i_srst     (resetIn),
    .i_load     (loadEnableIn),
    .i_load_val ('0),
    .i_inc      (w_rd_acc),
    .o_ptr      (w_head)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .i_clk      (clkIn),
    .i_srst     (resetIn),
    .i_load     (loadEnableIn),
    .i_load_val (w_load_tail),
    .i_inc      (w_wr_acc),
    .o_ptr      (w_tail)
  );

  // Next occupancy; the status flags are registered from it so they line up
  // with count in the same cycle.
  always_comb begin
    w_count_next = r_count;
    if (resetIn) begin
      w_count_next = '0;
    end else if (loadEnableIn) begin
      w_count_next = w_load_cnt;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Storage is never cleared by reset; a load that coincides with reset is
  // discarded.
  always_ff @(posedge clkIn) begin
    if (!resetIn && loadEnableIn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= loadIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (w_wr_acc) begin
      r_mem[w_tail] <= dataIn;
    end
  end

  always_ff @(posedge clkIn) begin
    r_count        <= w_count_next;
    r_empty        <= (w_count_next == '0);
    r_full         <= (w_count_next == DEPTH_C);
    r_almost_full  <= (w_count_next >= AF_TH);
    r_almost_empty <= (w_count_next <= AE_TH);
    if (resetIn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data <= r_mem[w_head];
      end
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clkIn) begin
    if (resetIn || loadEnableIn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (writeEnableIn && r_full && !w_rd_acc) begin
        r_overflow <= 1'b1;
      end
      if (readEnableIn && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflowOut  = r_overflow;
  assign underflowOut = r_underflow;
`else
  assign overflowOut  = 1'b0;
  assign underflowOut = 1'b0;
`endif

  assign dataOut      = r_data;
  assign dataValidOut = r_valid;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almostFull   = r_almost_full;
  assign almostEmpty  = r_almost_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Randomised and directed stimulus for sync_fifo (DEPTH=5, non-power-of-two)
// checked every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AF_TH = DEPTH - 1;
  localparam int AE_TH = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wen;
  logic [DW-1:0]         din;
  logic                  ren;
  logic                  ld;
  logic [DEPTH*DW-1:0]   ld_img;
  logic [CW-1:0]         ld_cnt;
  logic [DW-1:0]         dout;
  logic                  dvalid;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic                  aempty;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic                  unf;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clkIn         (clk),
    .resetIn       (rst),
    .writeEnableIn (wen),
    .dataIn        (din),
    .readEnableIn  (ren),
    .loadEnableIn  (ld),
    .loadIn        (ld_img),
    .loadCountIn   (ld_cnt),
    .dataOut       (dout),
    .dataValidOut  (dvalid),
    .full          (full),
    .empty         (empty),
    .almostFull    (afull),
    .almostEmpty   (aempty),
    .count         (cnt),
    .overflowOut   (ovf),
    .underflowOut  (unf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus the last popped word.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic [DW-1:0] d,
                              input logic rd_req, input logic l, input logic [CW-1:0] lc);
    int  n;
    bit  rd_ok;
    bit  wr_ok;
    if (r) begin
      m_q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else if (l) begin
      n = (int'(lc) > DEPTH) ? DEPTH : int'(lc);
      m_q.delete();
      for (int i = 0; i < n; i++) m_q.push_back(ld_img[i*DW +: DW]);
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      rd_ok   = rd_req && (m_q.size() > 0);
      wr_ok   = w && ((m_q.size() < DEPTH) || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) m_data = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_req && !rd_ok) m_unf = 1'b1;
`endif
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check at negedge.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd_req, input logic l, input logic [CW-1:0] lc);
    rst = r; wen = w; din = d; ren = rd_req; ld = l; ld_cnt = lc;
    @(posedge clk);
    model_update(r, w, d, rd_req, l, lc);
    @(negedge clk);
    $display("t=%0t rst=%0b wr=%0b din=%h rd=%0b ld=%0b lc=%0d | cnt=%0d dout=%h v=%0b",
             $time, r, w, d, rd_req, l, lc, cnt, dout, dvalid);
    check_val("count",       32'(cnt),    32'(m_q.size()));
    check_val("empty",       32'(empty),  32'(m_q.size() == 0));
    check_val("full",        32'(full),   32'(m_q.size() == DEPTH));
    check_val("almostFull",  32'(afull),  32'(m_q.size() >= AF_TH));
    check_val("almostEmpty", 32'(aempty), 32'(m_q.size() <= AE_TH));
    check_val("dataOut",     32'(dout),   32'(m_data));
    check_val("dataValid",   32'(dvalid), 32'(m_valid));
    check_val("overflow",    32'(ovf),    32'(m_ovf));
    check_val("underflow",   32'(unf),    32'(m_unf));
  endtask

  task automatic set_image_pattern(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) ld_img[i*DW +: DW] = base + DW'(i);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; din = '0; ren = 1'b0; ld = 1'b0; ld_cnt = '0;
    ld_img = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);

    // Fill to full, then one rejected write
    for (int k = 1; k <= DEPTH; k++) step(0, 1, DW'(16'h1111 * k), 0, 0, 0);
    step(0, 1, 16'h6666, 0, 0, 0);

    // Drain in order, then one read on empty
    for (int k = 0; k <= DEPTH; k++) step(0, 0, 0, 1, 0, 0);

    // Two in flight: writes lead reads by two cycles, exercising wrap 4->0
    for (int k = 0; k < 14; k++) step(0, k < 12, DW'(16'h0100 + k), k >= 2, 0, 0);

    // Full with simultaneous read and write
    for (int k = 0; k < DEPTH; k++) step(0, 1, DW'(16'h2000 + k), 0, 0, 0);
    step(0, 1, 16'hBEEF, 1, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 1, 0, 0);

    // Empty with simultaneous read and write
    step(0, 1, 16'h1234, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Preload three entries of 0xA0.. image, drain past empty
    set_image_pattern(16'h00A0);
    step(0, 0, 0, 0, 1, 3);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 0);

    // Oversized load count saturates; traffic during load ignored
    step(0, 1, 16'hDEAD, 1, 1, CW'(7));
    step(0, 1, 16'hCAFE, 1, 0, 0);

    // Reset during load: loaded data must not appear
    set_image_pattern(16'h0B00);
    step(1, 0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 0, 0);

    // Reset during streaming
    step(0, 1, 16'h5151, 0, 0, 0);
    step(0, 1, 16'h5252, 1, 0, 0);
    step(1, 1, 16'h5353, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Randomised traffic with occasional loads and resets
    for (int k = 0; k < 600; k++) begin
      logic r_r;
      logic r_l;
      r_r = ($urandom_range(0, 99) == 0);
      r_l = ($urandom_range(0, 29) == 0);
      if (r_l) begin
        for (int i = 0; i < DEPTH; i++) ld_img[i*DW +: DW] = DW'($urandom);
      end
      step(r_r, $urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
           r_l, CW'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
